// File: rtl/decode_pkg.sv
// Shared decode types, field positions and opcode class helpers.
// Used by instruction_decode and register_file.
package decode_pkg;

    localparam int REG_COUNT = 16;

    localparam int OP_LSB  = 28;
    localparam int RD_LSB  = 24;
    localparam int RS1_LSB = 20;
    localparam int RS2_LSB = 16;
    localparam int IMM_LSB = 0;

    typedef enum logic [3:0] {
        OP_NOP   = 4'h0,
        OP_ADD   = 4'h1,
        OP_SUB   = 4'h2,
        OP_AND   = 4'h3,
        OP_ADDI  = 4'h4,
        OP_SUBI  = 4'h5,
        OP_LOAD  = 4'h8,
        OP_STORE = 4'h9,
        OP_BEQ   = 4'hC,
        OP_JMP   = 4'hD
    } opcode_e;

    typedef struct packed {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [15:0] imm;
    } instr_t;

    function automatic logic isLegal(input logic [3:0] op);
        return op inside {OP_NOP, OP_ADD, OP_SUB, OP_AND, OP_ADDI,
                          OP_SUBI, OP_LOAD, OP_STORE, OP_BEQ, OP_JMP};
    endfunction

    function automatic logic usesRs1(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_SUBI,
                          OP_LOAD, OP_STORE, OP_BEQ};
    endfunction

    function automatic logic usesRs2(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND};
    endfunction

    // rd acts as a source for STORE data and the BEQ comparand
    function automatic logic usesRd(input logic [3:0] op);
        return op inside {OP_STORE, OP_BEQ};
    endfunction

    function automatic logic writesRd(input logic [3:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_ADDI, OP_SUBI, OP_LOAD};
    endfunction

endpackage

// File: rtl/instruction_decode_if.sv
// IF/WB/EX-facing signal bundle of the decode stage.
// illegalInstr exists only when ID_ILLEGAL_TRAP_EN is defined.
interface instruction_decode_if #(
    parameter int PC_W = 24
);
    logic              ifValid;
    logic [31+PC_W:0]  ifBuffer;
    logic              exReady;
    logic              wbEn;
    logic [3:0]        wbReg;
    logic [31:0]       wbData;
    logic              stallIF;
    logic              branchFlag;
    logic [PC_W-1:0]   branchAddr;
    logic              idValid;
    logic [3:0]        idOpcode;
    logic [3:0]        idRd;
    logic [31:0]       idSrcA;
    logic [31:0]       idSrcB;
    logic [31:0]       idImm;
    logic [PC_W-1:0]   idPc;
`ifdef ID_ILLEGAL_TRAP_EN
    logic              illegalInstr;
`endif

    modport master (
`ifdef ID_ILLEGAL_TRAP_EN
        input  illegalInstr,
`endif
        output ifValid, ifBuffer, exReady, wbEn, wbReg, wbData,
        input  stallIF, branchFlag, branchAddr,
        input  idValid, idOpcode, idRd, idSrcA, idSrcB, idImm, idPc
    );

    modport slave (
`ifdef ID_ILLEGAL_TRAP_EN
        output illegalInstr,
`endif
        input  ifValid, ifBuffer, exReady, wbEn, wbReg, wbData,
        output stallIF, branchFlag, branchAddr,
        output idValid, idOpcode, idRd, idSrcA, idSrcB, idImm, idPc
    );

endinterface

// File: rtl/instruction_decode_register_file.sv
// 16x32 register file: 3 combinational read ports with WB bypass,
// one write port, R0 hardwired to zero, synchronous reset.
module register_file
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [3:0]  raddr_a,
    input  logic [3:0]  raddr_b,
    input  logic [3:0]  raddr_c,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] rdata_c
);

    logic [31:0] regs [REG_COUNT];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (we && waddr != 4'd0) begin
            regs[waddr] <= wdata;
        end
    end

    function automatic logic [31:0] read_port(input logic [3:0] addr);
        if (addr == 4'd0) return '0;
        if (we && waddr == addr) return wdata;
        return regs[addr];
    endfunction

    always_comb begin
        rdata_a = read_port(raddr_a);
        rdata_b = read_port(raddr_b);
        rdata_c = read_port(raddr_c);
    end

endmodule

// File: rtl/instruction_decode.sv
// ID stage: decode, regfile read, busy-counter hazards, branch resolve.
// Optional: ID_ILLEGAL_TRAP_EN traps illegal opcodes to TRAP_VECTOR.
module instruction_decode
    import decode_pkg::*;
#(
    parameter int              PC_W          = 24,
    parameter int              BRANCH_SHADOW = 1,
    parameter logic [PC_W-1:0] TRAP_VECTOR   = '0
)(
    input  logic              clk,
    input  logic              rst,
    instruction_decode_if.slave bus
);

    logic [31:0]     word;
    logic [PC_W-1:0] pc;
    instr_t          ins;
    logic [3:0]      op;
    logic [31:0]     imm_ext;
    logic [31:0]     val_a, val_b, val_c;

    assign word = bus.ifBuffer[PC_W +: 32];
    assign pc   = bus.ifBuffer[PC_W-1:0];
    assign ins  = '{op:  word[OP_LSB +: 4],
                    rd:  word[RD_LSB +: 4],
                    rs1: word[RS1_LSB +: 4],
                    rs2: word[RS2_LSB +: 4],
                    imm: word[IMM_LSB +: 16]};
    assign imm_ext = {{16{ins.imm[15]}}, ins.imm};

    register_file u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (bus.wbEn),
        .waddr   (bus.wbReg),
        .wdata   (bus.wbData),
        .raddr_a (ins.rs1),
        .raddr_b (ins.rs2),
        .raddr_c (ins.rd),
        .rdata_a (val_a),
        .rdata_b (val_b),
        .rdata_c (val_c)
    );

    logic [1:0] cnt [REG_COUNT];
    logic [1:0] squash;
    logic       hit_a, hit_b, hit_c;
    logic       busy_a, busy_b, busy_c;
    logic       writer, hazard, live, issue, taken, trap, exec;
    logic [REG_COUNT-1:0] inc, dec;

`ifdef ID_ILLEGAL_TRAP_EN
    assign op    = ins.op;
    assign trap  = issue && !isLegal(ins.op);
    assign bus.illegalInstr = trap;
`else
    logic unused_trap;
    assign op    = isLegal(ins.op) ? ins.op : OP_NOP;
    assign trap  = 1'b0;
    assign unused_trap = ^TRAP_VECTOR;
`endif

    // A same-cycle writeback cancels one outstanding write for the source
    always_comb begin
        hit_a  = bus.wbEn && bus.wbReg == ins.rs1;
        hit_b  = bus.wbEn && bus.wbReg == ins.rs2;
        hit_c  = bus.wbEn && bus.wbReg == ins.rd;
        busy_a = cnt[ins.rs1] > {1'b0, hit_a};
        busy_b = cnt[ins.rs2] > {1'b0, hit_b};
        busy_c = cnt[ins.rd]  > {1'b0, hit_c};
        writer = writesRd(op) && ins.rd != 4'd0;
        hazard = (usesRs1(op) && busy_a)
              || (usesRs2(op) && busy_b)
              || (usesRd(op)  && busy_c)
              || (writer && cnt[ins.rd] == 2'd3);
        live   = bus.ifValid && squash == 2'd0 && !rst;
        issue  = live && !hazard && bus.exReady;
        taken  = issue && (op == OP_JMP
                 || (op == OP_BEQ && val_c == val_a));
        exec   = issue && (writesRd(op) || op == OP_STORE);
    end

    assign bus.stallIF    = live && (hazard || !bus.exReady);
    assign bus.branchFlag = taken || trap;
    assign bus.branchAddr = taken ? pc + imm_ext[PC_W-1:0]
                          : trap  ? TRAP_VECTOR : '0;

    always_comb begin
        for (int r = 0; r < REG_COUNT; r++) begin
            inc[r] = issue && writer && ins.rd == 4'(r);
            dec[r] = bus.wbEn && bus.wbReg == 4'(r)
                     && r != 0 && cnt[r] != 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            squash <= '0;
            for (int r = 0; r < REG_COUNT; r++) cnt[r] <= '0;
        end else begin
            for (int r = 0; r < REG_COUNT; r++) begin
                if (inc[r] && !dec[r])
                    cnt[r] <= cnt[r] + 2'd1;
                else if (dec[r] && !inc[r])
                    cnt[r] <= cnt[r] - 2'd1;
            end
            if (taken || trap)
                squash <= 2'(BRANCH_SHADOW);
            else if (squash != 2'd0 && bus.ifValid)
                squash <= squash - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || (bus.exReady && !exec)) begin
            bus.idValid  <= 1'b0;
            bus.idOpcode <= '0;
            bus.idRd     <= '0;
            bus.idSrcA   <= '0;
            bus.idSrcB   <= '0;
            bus.idImm    <= '0;
            bus.idPc     <= '0;
        end else if (bus.exReady) begin
            bus.idValid  <= 1'b1;
            bus.idOpcode <= op;
            bus.idRd     <= ins.rd;
            bus.idSrcA   <= val_a;
            bus.idSrcB   <= usesRs2(op) ? val_b
                          : (op == OP_STORE) ? val_c : '0;
            bus.idImm    <= imm_ext;
            bus.idPc     <= pc;
        end
    end

endmodule

// File: tb/tb_instruction_decode.sv
// Bench for instruction_decode: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_instruction_decode;

    localparam int          SHADOW = 1;
    localparam logic [23:0] TRAP   = 24'h000000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    instruction_decode_if #(.PC_W(24)) bus();

    instruction_decode #(
        .PC_W(24), .BRANCH_SHADOW(SHADOW), .TRAP_VECTOR(TRAP)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [25:0]  exp_c;
    logic [128:0] exp_i;

    function automatic logic [25:0] comb_now();
        return {bus.stallIF, bus.branchFlag, bus.branchAddr};
    endfunction

    function automatic logic [128:0] idex_now();
        return {bus.idValid, bus.idOpcode, bus.idRd, bus.idSrcA,
                bus.idSrcB, bus.idImm, bus.idPc};
    endfunction

    function automatic logic [128:0] pk(input bit v, input logic [3:0] op,
            input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
            input logic [31:0] imm, input logic [23:0] pc);
        return {v, op, rd, a, b, imm, pc};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        bus.ifValid = 1'b0; bus.ifBuffer = '0; bus.exReady = 1'b1;
        bus.wbEn = 1'b0; bus.wbReg = '0; bus.wbData = '0;
    endtask

    task automatic apply_reset();
        rst = 1'b1; idle(); tick(); tick(); rst = 1'b0;
    endtask

    task automatic wb_preload(input logic [3:0] r, input logic [31:0] d);
        bus.ifValid = 1'b0;
        bus.wbEn = 1'b1; bus.wbReg = r; bus.wbData = d;
        tick();
        bus.wbEn = 1'b0;
    endtask

    task automatic set_instr(input logic [31:0] w, input logic [23:0] pc);
        bus.ifValid = 1'b1; bus.ifBuffer = {w, pc};
    endtask

    // ---------------- reference model ----------------
    logic [31:0]  m_regs [16];
    int           m_q[$];
    int           m_sq;
    logic [128:0] m_idex, n_idex;
    bit           e_stall, e_bf, e_issue, e_writer, e_trap;
    logic [23:0]  e_ba;
    int           e_rd;
    bit           c_wbe, c_ifv;
    int           c_wbr;
    logic [31:0]  c_wbd;

    function automatic int m_pend(input int r);
        int n;
        n = 0;
        foreach (m_q[i]) if (m_q[i] == r) n++;
        return n;
    endfunction

    function automatic logic [31:0] m_read(input int r);
        if (r == 0) return '0;
        if (bus.wbEn && int'(bus.wbReg) == r) return bus.wbData;
        return m_regs[r];
    endfunction

    function automatic void m_eval();
        logic [31:0] w, imm;
        logic [23:0] pc;
        int op, rd, rs1, rs2, p;
        int srcs[$];
        bit legal, rt, it, ld, st, beq, jmp, hz, live, tk;
        w   = bus.ifBuffer[55:24];
        pc  = bus.ifBuffer[23:0];
        op  = int'(w[31:28]); rd = int'(w[27:24]);
        rs1 = int'(w[23:20]); rs2 = int'(w[19:16]);
        imm = {{16{w[15]}}, w[15:0]};
        legal = op inside {0, 1, 2, 3, 4, 5, 8, 9, 12, 13};
`ifndef ID_ILLEGAL_TRAP_EN
        if (!legal) op = 0;
`endif
        rt = op inside {1, 2, 3}; it = op inside {4, 5};
        ld = op == 8; st = op == 9; beq = op == 12; jmp = op == 13;
        if (rt) begin srcs.push_back(rs1); srcs.push_back(rs2); end
        if (it || ld) srcs.push_back(rs1);
        if (st || beq) begin srcs.push_back(rs1); srcs.push_back(rd); end
        hz = 0;
        foreach (srcs[i]) begin
            p = m_pend(srcs[i]);
            if (bus.wbEn && int'(bus.wbReg) == srcs[i] && p > 0) p--;
            if (p > 0) hz = 1;
        end
        e_writer = (rt || it || ld) && rd != 0;
        if (e_writer && m_pend(rd) >= 3) hz = 1;
        live    = bus.ifValid && m_sq == 0;
        e_issue = live && !hz && bus.exReady;
        e_stall = live && (hz || !bus.exReady);
        tk      = e_issue && (jmp || (beq && m_read(rd) == m_read(rs1)));
`ifdef ID_ILLEGAL_TRAP_EN
        e_trap  = e_issue && !legal;
`else
        e_trap  = 0;
`endif
        e_bf = tk || e_trap;
        e_ba = tk ? pc + imm[23:0] : (e_trap ? TRAP : 24'h0);
        if (!bus.exReady) n_idex = m_idex;
        else if (e_issue && (rt || it || ld || st))
            n_idex = pk(1'b1, 4'(op), 4'(rd), m_read(rs1),
                        rt ? m_read(rs2) : (st ? m_read(rd) : 32'h0),
                        imm, pc);
        else n_idex = '0;
        e_rd  = rd;
        c_wbe = bus.wbEn; c_wbr = int'(bus.wbReg);
        c_wbd = bus.wbData; c_ifv = bus.ifValid;
    endfunction

    function automatic void m_commit();
        int idx;
        m_idex = n_idex;
        if (c_wbe) begin
            idx = -1;
            foreach (m_q[i]) if (idx < 0 && m_q[i] == c_wbr) idx = i;
            if (idx >= 0) m_q.delete(idx);
            if (c_wbr != 0) m_regs[c_wbr] = c_wbd;
        end
        if (e_issue && e_writer) m_q.push_back(e_rd);
        if (e_bf) m_sq = SHADOW;
        else if (m_sq > 0 && c_ifv) m_sq--;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; idle();
        set_instr(32'hD003FFF4, 24'd12);
        tick(); tick();
        exp_i = '0; checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL reset_idex got=%h exp=%h", idex_now(), exp_i); end
        @(negedge clk);
        exp_c = '0; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL reset_comb got=%h exp=%h", comb_now(), exp_c); end
        tick();
        rst = 1'b0; idle();
    endtask

    task automatic test_forward();
        apply_reset();
        wb_preload(4'd4, 32'h10);
        set_instr(32'h4C40004A, 24'h0);
        @(negedge clk); exp_c = '0; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL addi_comb got=%h exp=%h", comb_now(), exp_c); end
        tick();
        exp_i = pk(1, 4'h4, 4'd12, 32'h10, 32'h0, 32'h4A, 24'h0); checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL addi_idex got=%h exp=%h", idex_now(), exp_i); end
        set_instr(32'h11C40000, 24'h4);
        @(negedge clk); exp_c = {1'b1, 1'b0, 24'h0}; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL raw_stall got=%h exp=%h", comb_now(), exp_c); end
        tick();
        exp_i = '0; checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL raw_bubble got=%h exp=%h", idex_now(), exp_i); end
        bus.wbEn = 1'b1; bus.wbReg = 4'd12; bus.wbData = 32'h5A;
        @(negedge clk); exp_c = '0; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL raw_release got=%h exp=%h", comb_now(), exp_c); end
        tick();
        bus.wbEn = 1'b0; bus.ifValid = 1'b0;
        exp_i = pk(1, 4'h1, 4'd1, 32'h5A, 32'h10, 32'h0, 24'h4); checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL raw_bypass got=%h exp=%h", idex_now(), exp_i); end
    endtask

    task automatic test_jump();
        apply_reset();
        set_instr(32'hD003FFF4, 24'd12);
        @(negedge clk); exp_c = {1'b0, 1'b1, 24'h0}; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL jmp_comb got=%h exp=%h", comb_now(), exp_c); end
        tick();
        exp_i = '0; checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL jmp_bubble got=%h exp=%h", idex_now(), exp_i); end
        bus.ifValid = 1'b0;
        tick();
        set_instr(32'h42000001, 24'd100);
        @(negedge clk); exp_c = '0; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL squash_comb got=%h exp=%h", comb_now(), exp_c); end
        tick();
        exp_i = '0; checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL squash_drop got=%h exp=%h", idex_now(), exp_i); end
        set_instr(32'h43000002, 24'd104);
        tick();
        exp_i = pk(1, 4'h4, 4'd3, 32'h0, 32'h0, 32'h2, 24'd104); checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL post_squash got=%h exp=%h", idex_now(), exp_i); end
        set_instr(32'hD000FFF0, 24'h4);
        @(negedge clk); exp_c = {1'b0, 1'b1, 24'hFFFFF4}; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL jmp_wrap got=%h exp=%h", comb_now(), exp_c); end
        tick();
        bus.ifValid = 1'b0;
    endtask

    task automatic test_beq();
        apply_reset();
        wb_preload(4'd1, 32'd5);
        wb_preload(4'd2, 32'd6);
        set_instr(32'hC1200008, 24'h20);
        @(negedge clk); exp_c = '0; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL beq_ne got=%h exp=%h", comb_now(), exp_c); end
        tick();
        set_instr(32'h43000002, 24'h24);
        tick();
        exp_i = pk(1, 4'h4, 4'd3, 32'h0, 32'h0, 32'h2, 24'h24); checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL beq_no_squash got=%h exp=%h", idex_now(), exp_i); end
        wb_preload(4'd1, 32'd7);
        wb_preload(4'd2, 32'd7);
        set_instr(32'hC1200008, 24'h20);
        @(negedge clk); exp_c = {1'b0, 1'b1, 24'h28}; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL beq_eq got=%h exp=%h", comb_now(), exp_c); end
        tick();
        exp_i = '0; checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL beq_bubble got=%h exp=%h", idex_now(), exp_i); end
        bus.ifValid = 1'b0;
    endtask

    task automatic test_hold();
        apply_reset();
        wb_preload(4'd5, 32'h33);
        set_instr(32'h46500007, 24'h40);
        tick();
        exp_i = pk(1, 4'h4, 4'd6, 32'h33, 32'h0, 32'h7, 24'h40);
        set_instr(32'h17550000, 24'h44);
        bus.exReady = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); exp_c = {1'b1, 1'b0, 24'h0}; checks++;
            if (comb_now() !== exp_c) begin failures++;
                $display("FAIL hold_stall got=%h exp=%h", comb_now(), exp_c); end
            tick(); checks++;
            if (idex_now() !== exp_i) begin failures++;
                $display("FAIL hold_idex got=%h exp=%h", idex_now(), exp_i); end
        end
        bus.exReady = 1'b1;
        tick();
        bus.ifValid = 1'b0;
        exp_i = pk(1, 4'h1, 4'd7, 32'h33, 32'h33, 32'h0, 24'h44); checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL hold_release got=%h exp=%h", idex_now(), exp_i); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        for (int k = 1; k <= 3; k++) begin
            set_instr({16'h4100, 16'(k)}, 24'(4 * (k - 1)));
            tick();
            exp_i = pk(1, 4'h4, 4'd1, 32'h0, 32'h0, 32'(k), 24'(4 * (k - 1)));
            checks++;
            if (idex_now() !== exp_i) begin failures++;
                $display("FAIL b2b_issue got=%h exp=%h", idex_now(), exp_i); end
        end
        set_instr(32'h41000004, 24'd12);
        @(negedge clk); exp_c = {1'b1, 1'b0, 24'h0}; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL b2b_full got=%h exp=%h", comb_now(), exp_c); end
        tick();
        bus.wbEn = 1'b1; bus.wbReg = 4'd1; bus.wbData = 32'h11;
        @(negedge clk); checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL b2b_wb_same got=%h exp=%h", comb_now(), exp_c); end
        tick();
        bus.wbEn = 1'b0;
        tick();
        bus.ifValid = 1'b0;
        exp_i = pk(1, 4'h4, 4'd1, 32'h0, 32'h0, 32'h4, 24'd12); checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL b2b_drain got=%h exp=%h", idex_now(), exp_i); end
    endtask

    task automatic test_illegal();
        apply_reset();
        set_instr(32'hF1230000, 24'h50);
        @(negedge clk);
`ifdef ID_ILLEGAL_TRAP_EN
        exp_c = {1'b0, 1'b1, TRAP}; checks++;
        if ({comb_now(), bus.illegalInstr} !== {exp_c, 1'b1}) begin failures++;
            $display("FAIL trap_comb got=%h exp=%h",
                     {comb_now(), bus.illegalInstr}, {exp_c, 1'b1}); end
        tick();
        set_instr(32'h43000002, 24'h54);
        tick();
        exp_i = '0;
`else
        exp_c = '0; checks++;
        if (comb_now() !== exp_c) begin failures++;
            $display("FAIL illegal_nop got=%h exp=%h", comb_now(), exp_c); end
        tick();
        set_instr(32'h43000002, 24'h54);
        tick();
        exp_i = pk(1, 4'h4, 4'd3, 32'h0, 32'h0, 32'h2, 24'h54);
`endif
        checks++;
        if (idex_now() !== exp_i) begin failures++;
            $display("FAIL illegal_next got=%h exp=%h", idex_now(), exp_i); end
        bus.ifValid = 1'b0;
    endtask

    task automatic test_random();
        int ops[12] = '{0, 1, 2, 3, 4, 5, 8, 9, 12, 13, 6, 15};
        bit hold;
        logic [31:0] w;
        apply_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_q.delete(); m_sq = 0; m_idex = '0;
        hold = 0;
        for (int n = 0; n < 600; n++) begin
            if (!hold) begin
                bus.ifValid = $urandom_range(0, 4) != 0;
                w = {4'(ops[$urandom_range(0, 11)]),
                     4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                     4'($urandom_range(0, 7)), 16'($urandom)};
                bus.ifBuffer = {w, 24'($urandom)};
            end
            bus.exReady = $urandom_range(0, 4) != 0;
            if (m_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                bus.wbEn  = 1'b1;
                bus.wbReg = 4'(m_q[$urandom_range(0, m_q.size() - 1)]);
            end else begin
                bus.wbEn  = 1'b0;
                bus.wbReg = 4'($urandom);
            end
            bus.wbData = $urandom;
            m_eval();
            @(negedge clk);
            exp_c = {e_stall, e_bf, e_ba}; checks++;
            if (comb_now() !== exp_c) begin failures++;
                $display("FAIL rnd_comb n=%0d got=%h exp=%h", n, comb_now(), exp_c); end
`ifdef ID_ILLEGAL_TRAP_EN
            checks++;
            if (bus.illegalInstr !== e_trap) begin failures++;
                $display("FAIL rnd_illegal n=%0d got=%b exp=%b",
                         n, bus.illegalInstr, e_trap); end
`endif
            @(posedge clk);
            m_commit();
            #1; checks++;
            if (idex_now() !== m_idex) begin failures++;
                $display("FAIL rnd_idex n=%0d got=%h exp=%h", n, idex_now(), m_idex); end
            hold = e_stall;
        end
        idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        idle();
        test_reset();
        test_forward();
        test_jump();
        test_beq();
        test_hold();
        test_back_to_back();
        test_illegal();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
